mem_arbiter: RTL
================

# mem_arbiter

Single-port memory arbiter between the instruction-fetch and load/store units of the RV32 core, sitting directly in front of the unified word-addressed memory (asynchronous read, write on rising clk). Grants one requester per cycle with data priority and a fetch starvation guard. Sequences sub-word stores as a read-modify-write, because the memory has no byte enables. Flags misaligned data accesses without touching memory.

## Interface
- STARVE_MAX, 4: consecutive cycles fetch may be refused before it takes priority (1..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address (word-aligned, bits [1:0] ignored)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid; one-cycle pulse
- if_rdata  out  32  fetched word
- d_req  in  1  data request; held with d_we/d_size/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified for byte/half
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  load data valid or store complete; one-cycle pulse
- d_rdata  out  32  full aligned word for loads (extension done by core); 0 for stores
- d_misalign  out  1  qualifies d_rvalid: access was misaligned, not performed
- mem_addr  out  32  byte address to memory, bits [1:0] always 0
- mem_wdata  out  32  write word
- mem_we  out  1  memory write enable, at most one cycle per store
- mem_rdata  in  32  asynchronous memory read data

## Operation
- FSM states: IDLE, RMW.
- IDLE, winner selection: d_req wins, unless starve_cnt == STARVE_MAX and if_req, in which case fetch wins. Loser sees no gnt.
- gnt is combinational in the accepting cycle.
- Fetch grant: mem_addr = {if_addr[31:2],2'b00}, mem_we=0. mem_rdata is registered into if_rdata.
- Data load grant: same as fetch on d_addr; result goes to d_rdata.
- Word store grant: mem_we=1, mem_wdata=d_wdata.
- Sub-word store grant: read cycle, mem_we=0.
  - Latch mem_rdata, byte offset, size, wdata and word address.
  - Go to RMW.
- RMW: mem_addr = latched address, mem_wdata = merged word, mem_we=1. No grants in this state. Return to IDLE.
- Merge rule:
  - byte: lane d_addr[1:0] ← wdata[7:0].
  - half: lanes {addr[1],1}:{addr[1],0} ← wdata[15:0].
- Misaligned data access (half with addr[0]=1, word with addr[1:0]≠0):
  - granted normally; mem_we=0.
  - next cycle: d_rvalid=1 and d_misalign=1.
- starve_cnt (4 bits):
  - +1 per cycle with if_req=1 and if_gnt=0, saturating at STARVE_MAX.
  - cleared on if_gnt or if_req=0.
- Idle with no request: mem_addr=0, mem_we=0.

## Timing
- Reset values:
  - state=IDLE, starve_cnt=0.
  - if_gnt, d_gnt, if_rvalid, d_rvalid, d_misalign, mem_we = 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata = 0.
- Grant at cycle N: rvalid at N+1 for fetch, load, word store and misaligned access. Sub-word store: rvalid at N+2.
- Back-to-back grants allowed every cycle in IDLE. Sub-word store occupies 2 cycles.
- Both requests in the same cycle: exactly one gnt asserted.
- Requester may change inputs the cycle after gnt. Arbiter never re-samples them.
- Reset asserted in RMW: state forced IDLE asynchronously, so mem_we drops immediately and the partial store is dropped. No rvalid is issued.
- Request arriving during RMW: it waits, and starve_cnt still counts for fetch.

## Structure
- Package mem_arb_pkg holds:
  - size encodings SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - state enum {ST_IDLE, ST_RMW}.
  - misalign function (size, addr[1:0]).
- Sub-module store_merge: purely combinational; inputs old word, wdata, size, offset; output merged word. Reused later by the cache.

## Test plan
- Fetch only, if_addr=0x100, mem word 0xDEADBEEF: if_gnt at N, if_rvalid with if_rdata=0xDEADBEEF at N+1, mem_we never 1.
- Both request every cycle, STARVE_MAX=4: d_gnt 4 cycles, then if_gnt in cycle 5, then starve_cnt=0.
- sb 0xAB to 0x203 over word 0x11223344: read cycle, then mem_we=1 with 0xAB223344, d_rvalid at N+2.
- sh 0xBEEF to 0x202 over 0x11223344: write 0xBEEF3344. Then lw 0x200 returns 0xBEEF3344.
- lw 0x202: d_gnt, then d_rvalid=1 and d_misalign=1 at N+1, mem_we=0 throughout.
- rst_n low during RMW of sb: mem_we=0 immediately, memory word unchanged, no d_rvalid; after release, fetch resumes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the memory arbiter and store merge logic.
package mem_arb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {ST_IDLE, ST_RMW} state_e;

  // Half needs 2-byte alignment, word (and size 11) needs 4-byte alignment.
  function automatic logic misalign(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    misalign = 1'b0;
      SZ_H:    misalign = off[0];
      default: misalign = |off;
    endcase
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational byte/half lane merge of store data into an existing word.
module store_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  output logic [31:0] merged_o
);

  // Replace only the addressed lanes; word size passes the store data through.
  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_B:    merged_o[{off_i, 3'b000} +: 8]      = wdata_i[7:0];
      SZ_H:    merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs load/store, data priority with a
// fetch starvation guard, sub-word stores done as read-modify-write.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] old_q, wdata_q, addr_q;
  logic [1:0]  size_q, off_q;
  logic        if_rvalid_q, d_rvalid_q, d_misalign_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        f_win, d_win, d_mis, d_sub;
  logic [31:0] merged;

  // Fetch word-aligns its address by construction; low bits carry no meaning.
  logic unused_if_lsb;
  assign unused_if_lsb = ^if_addr[1:0];

  store_merge u_merge (
    .old_i   (old_q),
    .wdata_i (wdata_q),
    .size_i  (size_q),
    .off_i   (off_q),
    .merged_o(merged)
  );

  // Winner selection, memory port drive and next state.
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    f_win     = 1'b0;
    d_win     = 1'b0;
    d_mis     = misalign(d_size, d_addr[1:0]);
    d_sub     = d_we && !d_size[1] && !d_mis;
    case (state_q)
      ST_IDLE: begin
        f_win = if_req && (!d_req || starve_q == SMAX);
        d_win = d_req && !f_win;
        if (f_win) begin
          if_gnt   = 1'b1;
          mem_addr = {if_addr[31:2], 2'b00};
        end else if (d_win) begin
          d_gnt    = 1'b1;
          mem_addr = {d_addr[31:2], 2'b00};
          // Full-word aligned store writes directly; misaligned never writes.
          if (d_we && d_size[1] && !d_mis) begin
            mem_we    = 1'b1;
            mem_wdata = d_wdata;
          end
          if (d_sub) state_d = ST_RMW;
        end
      end
      ST_RMW: begin
        mem_addr  = addr_q;
        mem_wdata = merged;
        mem_we    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Refused-fetch counter, saturating; clears on grant or request drop.
  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) starve_d = (starve_q == SMAX) ? SMAX : starve_q + 4'd1;
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Capture the read half of a sub-word store for the write-back cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      old_q   <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
    end else if (d_win && d_sub) begin
      old_q   <= mem_rdata;
      wdata_q <= d_wdata;
      size_q  <= d_size;
      off_q   <= d_addr[1:0];
      addr_q  <= {d_addr[31:2], 2'b00};
    end
  end

  // Response pulses one cycle after grant (or after the RMW write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rvalid_q   <= 1'b0;
      d_misalign_q <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      if_rvalid_q  <= f_win;
      if (f_win) if_rdata_q <= mem_rdata;
      d_rvalid_q   <= (d_win && !d_sub) || (state_q == ST_RMW);
      d_misalign_q <= d_win && d_mis;
      if (d_win && !d_sub) d_rdata_q <= (d_we || d_mis) ? '0 : mem_rdata;
      else if (state_q == ST_RMW) d_rdata_q <= '0;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rvalid   = d_rvalid_q;
  assign d_misalign = d_misalign_q;
  assign d_rdata    = d_rdata_q;

endmodule
